sram22_sp_sram_model_v2: RTL

Parametrised behavioural model of a single-port SRAM22 macro, successor to the fixed 512x32 single-mask model. It adds per-lane write masking, a request enable, selectable 1- or 2-cycle read latency with a valid strobe, selectable read-during-write behaviour, and a post-reset hardware clear sequencer. It replaces the fixed models in simulation and is a drop-in target for integration tests.

---
 rtl/sram22_sp_sram_model_v2.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sram22_sp_sram_model_v2.sv
`default_nettype none
// ============================================================================
// Module   : sram22_sp_sram_model_v2
// Purpose  : Behavioural model of a single-port SRAM22 macro with per-lane
//            write masking, 1- or 2-cycle read latency, selectable
//            read-during-write return and a post-reset hardware clear.
// Revision : v2.0 - parametrised successor to the fixed 512x32 model
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset, restarts the clear
//   en         in   request valid, sampled only while ready=1
//   we         in   1 = write, 0 = read
//   wmask      in   per-lane write enable, bit i covers din[i*LW +: LW]
//   addr       in   word address
//   din        in   write data
//   dout       out  read data, holds between valid strobes
//   dout_valid out  one-cycle strobe, dout updated this cycle
//   ready      out  clear sequence done, requests accepted
// ============================================================================
module sram22_sp_sram_model_v2 #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int WMASK_WIDTH  = 4,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   ready
);

    localparam int                  c_RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int                  c_LW        = DATA_WIDTH / WMASK_WIDTH;
    localparam logic                c_WF        = (WRITE_FIRST != 0);
    localparam logic [ADDR_WIDTH-1:0] c_CLR_LAST = '1;

    localparam logic [0:0] c_S_CLEAR = 1'b0;
    localparam logic [0:0] c_S_RUN   = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  w_ready;
    logic                  w_clearing;

    logic [DATA_WIDTH-1:0] r_mem [c_RAM_DEPTH];
    logic [DATA_WIDTH-1:0] w_mem_rd;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_ret_word;
    logic                  w_clr_wr;
    logic                  w_req_wr;
    logic                  w_issue;

    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // The edge that clears the last word also enters RUN.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_S_CLEAR && r_clr_cnt == c_CLR_LAST) begin
            w_state_nxt = c_S_RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready    = 1'b0;
        w_clearing = 1'b0;
        case (r_state)
            c_S_RUN:   w_ready    = 1'b1;
            default:   w_clearing = 1'b1;
        endcase
    end

    assign ready = w_ready;

    // Clear address counter; wraps back to zero on the final clear edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (w_clearing) begin
            r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
        end
    end

    // ---------------- Memory array ----------------
    // The clear write is held off while rst is high so that only rst-low
    // edges count as clear cycles.
    assign w_clr_wr = w_clearing & ~rst;
    assign w_req_wr = w_ready & en & we;
    assign w_mem_rd = r_mem[addr];

    for (genvar i = 0; i < WMASK_WIDTH; i++) begin : g_lane
        assign w_merged[i*c_LW +: c_LW] = wmask[i] ? din[i*c_LW +: c_LW]
                                                   : w_mem_rd[i*c_LW +: c_LW];
    end

    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_req_wr) begin
            r_mem[addr] <= w_merged;
        end
    end

    // ---------------- Read return pipeline ----------------
    // A write returns the merged word so the same-edge read-during-write
    // result never exposes the old contents.
    assign w_issue    = w_ready & en & (~we | c_WF);
    assign w_ret_word = we ? w_merged : w_mem_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_s1_data <= w_ret_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_s2_data;
        logic                  r_s2_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign dout       = r_s2_data;
        assign dout_valid = r_s2_valid;
    end else begin : g_lat1
        assign dout       = r_s1_data;
        assign dout_valid = r_s1_valid;
    end

endmodule
`default_nettype wire
